myproject_dense_accum: RTL and testbench



---
 rtl/myproject_dense_accum.sv | 137 +++++++++++++
 tb/tb_myproject_dense_accum.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_dense_accum.sv
// myproject_dense_accum
// Per-neuron dense-layer accumulator: sums N_IN signed products onto a bias
// sampled with the first product, arithmetic-shifts the total right by
// OUT_SHIFT (floor), narrows it to OUT_WIDTH and holds the result behind a
// valid/ready handshake until the next stage takes it.
//
// Optional build macro: ACCUM_SATURATE_EN
//   defined   -> narrowing clamps to the signed OUT_WIDTH range
//   undefined -> narrowing keeps the low OUT_WIDTH bits (two's-complement wrap)
module myproject_dense_accum #(
  parameter int unsigned PROD_WIDTH = 21,
  parameter int unsigned N_IN       = 16,
  parameter int unsigned ACC_WIDTH  = 26,
  parameter int unsigned OUT_SHIFT  = 6,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [ACC_WIDTH-1:0]  bias_in,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;

  logic                         accept;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [OUT_WIDTH-1:0]         narrowed;

  assign prod_ready = (state_q == ST_ACCUM) & ~ap_rst;
  assign accept     = prod_valid & prod_ready;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

  // Datapath: sign-extend the product, start from the bias on the first
  // product of a group, then realign and narrow the running sum.
  always_comb begin
    prod_ext = ACC_WIDTH'($signed(prod_in));
    acc_base = (cnt_q == '0) ? $signed(bias_in) : acc_q;
    acc_sum  = acc_base + prod_ext;
    shifted  = acc_sum >>> OUT_SHIFT;
  end

`ifdef ACCUM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the realigned sum into the signed output range.
  always_comb begin
    if (shifted > SAT_MAX) begin
      narrowed = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      narrowed = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      narrowed = shifted[OUT_WIDTH-1:0];
    end
  end
`else
  // Keep the low bits of the realigned sum (two's-complement wrap).
  always_comb begin
    narrowed = OUT_WIDTH'(shifted);
  end
`endif

  // Next-state logic: accumulate in ACCUM, hold the result in OUTPUT until
  // the downstream handshake completes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_sum;
          if (cnt_q == CNT_LAST) begin
            out_data_d  = narrowed;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_OUTPUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and result registers with synchronous reset discarding any
  // partial sum or pending result.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_myproject_dense_accum.sv
// Testbench for myproject_dense_accum: two instances (OUT_SHIFT 0 and 6,
// N_IN 4) share one stimulus stream; an integer-arithmetic reference model
// predicts handshakes and results cycle by cycle.
module tb_myproject_dense_accum;

  localparam int unsigned N = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [20:0] prod_in;
  logic        prod_valid;
  logic [25:0] bias_in;
  logic        out_ready;
  logic        prod_ready0, prod_ready1;
  logic [15:0] out_data0, out_data1;
  logic        out_valid0, out_valid1;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_cnt;
  longint      m_sum;
  bit          m_busy;
  logic [15:0] m_d0, m_d1;
  int          m_groups;

  always #5 ap_clk = ~ap_clk;

  myproject_dense_accum #(
    .PROD_WIDTH(21), .N_IN(N), .ACC_WIDTH(26), .OUT_SHIFT(0), .OUT_WIDTH(16)
  ) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready0), .bias_in(bias_in), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  myproject_dense_accum #(
    .PROD_WIDTH(21), .N_IN(N), .ACC_WIDTH(26), .OUT_SHIFT(6), .OUT_WIDTH(16)
  ) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready1), .bias_in(bias_in), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  function automatic logic [15:0] narrow(input longint s, input int sh);
    longint v;
    v = s >>> sh;
`ifdef ACCUM_SATURATE_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return 16'(v);
  endfunction

  // Advance one clock and update the model; inputs must already be set.
  task automatic tick();
    bit     rst_s, acc_s, ordy_s;
    longint p, b;
    rst_s  = ap_rst;
    acc_s  = prod_valid && !m_busy && !ap_rst;
    ordy_s = out_ready;
    p      = longint'($signed(prod_in));
    b      = longint'($signed(bias_in));
    @(posedge ap_clk);
    if (rst_s) begin
      m_cnt = 0; m_sum = 0; m_busy = 0; m_d0 = '0; m_d1 = '0;
    end else if (acc_s) begin
      m_sum = ((m_cnt == 0) ? b : m_sum) + p;
      if (m_cnt == N - 1) begin
        m_cnt = 0; m_busy = 1; m_groups++;
        m_d0 = narrow(m_sum, 0);
        m_d1 = narrow(m_sum, 6);
      end else begin
        m_cnt++;
      end
    end else if (m_busy && ordy_s) begin
      m_busy = 0;
    end
    #1;
  endtask

  // Drive one group back-to-back; bias is scrambled after the first accept.
  task automatic feed(input longint b, input longint p[4]);
    bias_in = 26'(b);
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1;
      prod_in    = 21'(p[i]);
      tick();
      bias_in = 26'($urandom);
    end
    prod_valid = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; prod_valid = 1'b0; out_ready = 1'b0;
    prod_in = '0; bias_in = '0;
    m_cnt = 0; m_sum = 0; m_busy = 0; m_d0 = '0; m_d1 = '0; m_groups = 0;
    tick(); tick();
    checks++;
    if (prod_ready0 !== 1'b0 || prod_ready1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b want 0", prod_ready0, prod_ready1);
    end
    checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 16'd0 || out_data1 !== 16'd0) begin
      errors++; $display("FAIL reset_out: valid=%b data=%h/%h want 0", out_valid0, out_data0, out_data1);
    end
    ap_rst = 1'b0;
    #1;
    checks++;
    if (prod_ready0 !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", prod_ready0);
    end
  endtask

  task automatic test_basic();
    longint p[4] = '{100, -50, 7, 3};
    out_ready = 1'b1;
    feed(10, p);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'd70) begin
      errors++; $display("FAIL basic_result: valid=%b data=%0d want 1/70", out_valid0, $signed(out_data0));
    end
    checks++;
    if (prod_ready0 !== 1'b0) begin
      errors++; $display("FAIL basic_ready_busy: got %b want 0", prod_ready0);
    end
    checks++;
    if (out_data1 !== m_d1) begin
      errors++; $display("FAIL basic_shift6: got %h want %h", out_data1, m_d1);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || prod_ready0 !== 1'b1) begin
      errors++; $display("FAIL basic_release: valid=%b ready=%b want 0/1", out_valid0, prod_ready0);
    end
  endtask

  task automatic test_saturation();
    longint pp[4] = '{1048575, 1048575, 1048575, 1048575};
    longint pn[4] = '{-1048576, -1048576, -1048576, -1048576};
    logic [15:0] exp_p, exp_n;
`ifdef ACCUM_SATURATE_EN
    exp_p = 16'h7FFF; exp_n = 16'h8000;
`else
    exp_p = 16'hFFFC; exp_n = 16'h0000;
`endif
    out_ready = 1'b1;
    feed(0, pp);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== exp_p) begin
      errors++; $display("FAIL sat_pos: valid=%b data=%h want 1/%h", out_valid0, out_data0, exp_p);
    end
    checks++;
    if (out_data1 !== m_d1) begin
      errors++; $display("FAIL sat_pos_shift6: got %h want %h", out_data1, m_d1);
    end
    tick();
    feed(0, pn);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== exp_n) begin
      errors++; $display("FAIL sat_neg: valid=%b data=%h want 1/%h", out_valid0, out_data0, exp_n);
    end
    tick();
  endtask

  task automatic test_shift_floor();
    longint pa[4] = '{-1, 0, 0, 0};
    longint pb[4] = '{127, 0, 0, 0};
    out_ready = 1'b1;
    feed(0, pa);
    checks++;
    if (out_data1 !== 16'hFFFF) begin
      errors++; $display("FAIL floor_neg: got %h want ffff", out_data1);
    end
    tick();
    feed(0, pb);
    checks++;
    if (out_data1 !== 16'd1 || out_data0 !== 16'd127) begin
      errors++; $display("FAIL floor_pos: got %0d/%0d want 1/127", out_data1, out_data0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    longint p[4];
    logic [15:0] held;
    for (int i = 0; i < 4; i++) p[i] = longint'($urandom_range(0, 4000)) - 2000;
    out_ready = 1'b0;
    feed(longint'($urandom_range(0, 1000)), p);
    held = out_data0;
    checks++;
    if (out_data0 !== m_d0 || out_data1 !== m_d1) begin
      errors++; $display("FAIL bp_result: got %h/%h want %h/%h", out_data0, out_data1, m_d0, m_d1);
    end
    for (int c = 0; c < 5; c++) begin
      prod_valid = 1'b1;
      prod_in    = 21'($urandom);
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || prod_ready0 !== 1'b0 || out_data0 !== held) begin
        errors++;
        $display("FAIL bp_hold: valid=%b ready=%b data=%h want 1/0/%h", out_valid0, prod_ready0, out_data0, held);
      end
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || prod_ready0 !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid0, prod_ready0);
    end
  endtask

  task automatic test_reset_mid_group();
    longint p[4] = '{1, 1, 1, 1};
    out_ready  = 1'b1;
    bias_in    = 26'(500);
    prod_valid = 1'b1;
    prod_in    = 21'(321);
    tick();
    prod_in = 21'(654);
    tick();
    prod_valid = 1'b0;
    ap_rst = 1'b1;
    #1;
    checks++;
    if (prod_ready0 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ready: got %b want 0", prod_ready0);
    end
    tick();
    ap_rst = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 16'd0) begin
      errors++; $display("FAIL rst_mid_out: valid=%b data=%h want 0/0", out_valid0, out_data0);
    end
    feed(1, p);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'd5) begin
      errors++; $display("FAIL rst_mid_fresh: valid=%b data=%0d want 1/5", out_valid0, out_data0);
    end
    tick();
  endtask

  // Random gaps, random data and bias every cycle; ready_mode=1 holds
  // out_ready high, otherwise it toggles randomly.
  task automatic test_back_to_back(input int n_groups, input bit ready_mode);
    int start, cyc;
    start = m_groups;
    cyc   = 0;
    while ((m_groups - start) < n_groups && cyc < 3000) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_in    = 21'($urandom);
      bias_in    = 26'(longint'($urandom_range(0, 8388608)) - 4194304);
      out_ready  = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
      checks++;
      if (prod_ready0 !== !m_busy || prod_ready1 !== !m_busy) begin
        errors++; $display("FAIL b2b_ready: got %b/%b want %b", prod_ready0, prod_ready1, !m_busy);
      end
      tick();
      cyc++;
      checks++;
      if (out_valid0 !== m_busy || out_valid1 !== m_busy) begin
        errors++; $display("FAIL b2b_valid: got %b/%b want %b", out_valid0, out_valid1, m_busy);
      end
      checks++;
      if (out_data0 !== m_d0 || out_data1 !== m_d1) begin
        errors++; $display("FAIL b2b_data: got %h/%h want %h/%h", out_data0, out_data1, m_d0, m_d1);
      end
    end
    checks++;
    if ((m_groups - start) < n_groups) begin
      errors++; $display("FAIL b2b_timeout: groups %0d want %0d", m_groups - start, n_groups);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_shift_floor();
    test_backpressure();
    test_reset_mid_group();
    test_back_to_back(3, 1'b1);
    test_back_to_back(20, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
